// File: rtl/song_sequencer_if.sv
// song_sequencer_if: ROM bus and note-player handshake of the song sequencer.
//   rom_addr   sequencer -> ROM     {song_q, idx}
//   rom_data   ROM -> sequencer     {note, duration}
//   new_note   sequencer -> player  one-cycle strobe, note/duration valid
//   note       sequencer -> player  registered note
//   duration   sequencer -> player  registered duration
//   note_done  player -> sequencer  one-cycle strobe, note finished
//   song_done  sequencer -> host    one-cycle strobe at song end
//   note_index sequencer -> host    current note index
interface song_sequencer_if #(
  parameter int NOTE_W    = 6,
  parameter int DUR_W     = 6,
  parameter int SONG_BITS = 2,
  parameter int IDX_BITS  = 5
);
  logic [SONG_BITS+IDX_BITS-1:0] rom_addr;
  logic [NOTE_W+DUR_W-1:0]       rom_data;
  logic                          new_note;
  logic [NOTE_W-1:0]             note;
  logic [DUR_W-1:0]              duration;
  logic                          note_done;
  logic                          song_done;
  logic [IDX_BITS-1:0]           note_index;

  modport master (
    output rom_addr, new_note, note, duration, song_done, note_index,
    input  rom_data, note_done
  );

  modport slave (
    input  rom_addr, new_note, note, duration, song_done, note_index,
    output rom_data, note_done
  );
endinterface

// File: rtl/song_sequencer.sv
// song_sequencer: walks the notes of the selected song in an external ROM and
// hands each one to the note player, advancing on note_done.
//   clk      rising-edge clock
//   reset    asynchronous, active-high
//   play     level, run (1) / pause (0)
//   song     song select; a change rewinds to note 0 of the new song
//   loop     level, wrap to note 0 at song end
//   restart  one-cycle pulse, rewind to note 0 of the current song
//   bus      ROM bus + player handshake (master side)
module song_sequencer #(
  parameter int NOTE_W      = 6,
  parameter int DUR_W       = 6,
  parameter int SONG_BITS   = 2,
  parameter int IDX_BITS    = 5,
  parameter int ROM_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play,
  input  logic [SONG_BITS-1:0] song,
  input  logic                 loop,
  input  logic                 restart,
  song_sequencer_if.master     bus
);

  typedef enum logic [2:0] {PAUSE, FETCH, CHECK, ISSUE, WAIT_DONE, DONE} state_t;

  localparam logic [1:0]          LAT_LAST = 2'(ROM_LATENCY - 1);
  localparam logic [IDX_BITS-1:0] IDX_LAST = '1;
  localparam logic [IDX_BITS-1:0] IDX_ONE  = IDX_BITS'(1);

  state_t               state, state_d;
  logic [SONG_BITS-1:0] song_q, song_d;
  logic [IDX_BITS-1:0]  idx, idx_d;
  logic [1:0]           lat_cnt, lat_d;
  logic [NOTE_W-1:0]    note_q, rom_note;
  logic [DUR_W-1:0]     dur_q, rom_dur;
  logic                 load, sd_reg, sd_reg_d, sd_now, trig;

  assign rom_note = bus.rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur  = bus.rom_data[DUR_W-1:0];
  assign trig     = restart || (song != song_q);

  always_comb begin
    state_d  = state;
    idx_d    = idx;
    song_d   = song_q;
    lat_d    = lat_cnt;
    load     = 1'b0;
    sd_reg_d = 1'b0;
    sd_now   = 1'b0;
    if (trig) begin
      // rewind wins over note_done and over any end-of-song handling
      song_d  = song;
      idx_d   = '0;
      lat_d   = '0;
      state_d = play ? FETCH : PAUSE;
    end else begin
      case (state)
        PAUSE: if (play) begin
          state_d = FETCH;
          lat_d   = '0;
        end
        FETCH: begin
          if (!play)                   state_d = PAUSE;
          else if (lat_cnt == LAT_LAST) state_d = CHECK;
          else                         lat_d   = lat_cnt + 2'd1;
        end
        CHECK: begin
          if (rom_dur == '0) begin
            // zero duration marks the end of the song; song_done is
            // combinational so it lands in this CHECK cycle
            sd_now = 1'b1;
            if (loop) begin
              idx_d   = '0;
              lat_d   = '0;
              state_d = FETCH;
            end else begin
              state_d = DONE;
            end
          end else begin
            load    = 1'b1;
            state_d = ISSUE;
          end
        end
        ISSUE: state_d = WAIT_DONE;
        WAIT_DONE: begin
          if (bus.note_done) begin
            lat_d = '0;
            if (idx == IDX_LAST) begin
              sd_reg_d = 1'b1;
              idx_d    = '0;
              state_d  = !loop ? DONE : (play ? FETCH : PAUSE);
            end else begin
              idx_d   = idx + IDX_ONE;
              state_d = play ? FETCH : PAUSE;
            end
          end else if (!play) begin
            state_d = PAUSE;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = PAUSE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= PAUSE;
      idx     <= '0;
      song_q  <= '0;
      lat_cnt <= '0;
      note_q  <= '0;
      dur_q   <= '0;
      sd_reg  <= 1'b0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      song_q  <= song_d;
      lat_cnt <= lat_d;
      sd_reg  <= sd_reg_d;
      if (load) begin
        note_q <= rom_note;
        dur_q  <= rom_dur;
      end
    end
  end

  assign bus.rom_addr   = {song_q, idx};
  assign bus.new_note   = (state == ISSUE);
  assign bus.note       = note_q;
  assign bus.duration   = dur_q;
  assign bus.song_done  = sd_now | sd_reg;
  assign bus.note_index = idx;

endmodule
